// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: accepts bitstream words over valid/ready and shifts them
// MSB first into the configuration flip-flop chain, one bit per prog_en cycle.
// Optional CRC-16-CCITT of the shifted stream when CCFF_LOADER_CRC_EN is defined.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 32,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              prog_en,
  output logic              busy,
  output logic [CNT_W-1:0]  bits_left,
  output logic              done,
  output logic              aborted
`ifdef CCFF_LOADER_CRC_EN
  ,
  output logic [15:0]       crc
`endif
);

  localparam int BC_W = $clog2(WORD_W+1);

  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;

  state_t            state;
  logic [WORD_W-1:0] buf_q;
  logic [BC_W-1:0]   buf_cnt;

  logic              acc;
  logic              do_shift;
  logic              shift_bit;
  logic [WORD_W-1:0] nxt_buf;
  logic [BC_W-1:0]   nxt_cnt;
  logic [CNT_W-1:0]  nxt_bl;
  logic              nxt_rdy;

  // Next buffer/counter values for one LOAD cycle. An accepted word into an
  // empty buffer shifts its MSB out immediately (1-cycle latency); a word
  // accepted while the last buffered bit leaves is loaded whole, so the
  // stream stays bubble-free.
  always_comb begin
    acc       = s_valid & s_ready;
    do_shift  = (state == LOAD) && !abort && (bits_left != '0) &&
                ((buf_cnt != '0) || acc);
    shift_bit = (buf_cnt != '0) ? buf_q[WORD_W-1] : s_data[WORD_W-1];
    nxt_buf   = buf_q;
    nxt_cnt   = buf_cnt;
    if ((buf_cnt != '0) && do_shift) begin
      nxt_buf = buf_q << 1;
      nxt_cnt = buf_cnt - BC_W'(1);
    end
    if (acc) begin
      if (buf_cnt == '0) begin
        nxt_buf = s_data << 1;
        nxt_cnt = BC_W'(WORD_W - 1);
      end else begin
        nxt_buf = s_data;
        nxt_cnt = BC_W'(WORD_W);
      end
    end
    nxt_bl  = do_shift ? bits_left - CNT_W'(1) : bits_left;
    // Ready only while the chain still needs bits beyond what is buffered.
    nxt_rdy = ((nxt_cnt == '0) && (nxt_bl != '0)) ||
              ((nxt_cnt == BC_W'(1)) && (nxt_bl > CNT_W'(1)));
  end

  // Control FSM with registered outputs; abort beats accept/shift in LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      buf_q     <= '0;
      buf_cnt   <= '0;
      s_ready   <= 1'b0;
      ccff_head <= 1'b0;
      prog_en   <= 1'b0;
      busy      <= 1'b0;
      bits_left <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      prog_en <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            bits_left <= CNT_W'(CHAIN_LEN);
            buf_cnt   <= '0;
            busy      <= 1'b1;
            s_ready   <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state   <= IDLE;
            buf_cnt <= '0;
            busy    <= 1'b0;
            s_ready <= 1'b0;
            aborted <= 1'b1;
          end else if (bits_left == '0) begin
            state   <= FIN;
            buf_cnt <= '0;
            busy    <= 1'b0;
            s_ready <= 1'b0;
            done    <= 1'b1;
          end else begin
            buf_q     <= nxt_buf;
            buf_cnt   <= nxt_cnt;
            bits_left <= nxt_bl;
            s_ready   <= nxt_rdy;
            if (do_shift) begin
              prog_en   <= 1'b1;
              ccff_head <= shift_bit;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CCFF_LOADER_CRC_EN
  // CRC-16-CCITT over every bit the chain actually captures.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      crc <= 16'hFFFF;
    else if ((state == IDLE) && start)
      crc <= 16'hFFFF;
    else if (prog_en)
      crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ ccff_head) ? 16'h1021 : 16'h0000);
  end
`endif

endmodule
